mdu_hilo_ctrl: RTL and testbench
================================

// Module: mdu_hilo_ctrl
// PURPOSE
//  Multi-cycle multiply/divide unit controller with HI/LO registers, in E stage.
//  Accepts one MDU op per cycle from E and sequences a fixed-latency busy window.
//  Commits HI/LO at the end of the window.
//  Drives hilo_busy to the D-stage conflict/stall unit.
//  Serves mfhi/mflo reads combinationally.
// PARAMETERS
//  MULT_CYCLES  5   busy cycles for mult/multu (>=1)
//  DIV_CYCLES   10  busy cycles for div/divu (>=1)
// PORTS
//  clk        in   1   clock; all state updates on rising edge
//  reset      in   1   synchronous, active-high
//  op         in   3   `MDU_NONE/MULT/MULTU/DIV/DIVU/MTHI/MTLO (E-stage decode)
//  A          in   32  rs value (forwarded)
//  B          in   32  rt value (forwarded)
//  rd_sel     in   1   0: out=LO, 1: out=HI (mflo/mfhi)
//  out        out  32  selected committed HI/LO value, combinational
//  busy       out  1   registered; high during the busy window
//  hilo_busy  out  1   busy | (op is mult/multu/div/divu && !busy); to stall unit
// BEHAVIOUR
//  Reset: HI=0, LO=0, busy=0, cnt=0, pending results=0.
//   Reset mid-operation aborts the op; HI/LO are cleared, not committed.
//  States: IDLE (busy=0), RUN (busy=1, cnt counts down).
//  IDLE + mult/multu/div/divu at edge t:
//   - compute full result from A,B and latch into hi_nxt/lo_nxt;
//   - cnt <= N (MULT_CYCLES or DIV_CYCLES), busy <= 1.
//  RUN:
//   - each edge cnt <= cnt-1;
//   - at the edge where cnt==1: HI<=hi_nxt, LO<=lo_nxt, busy<=0, back to IDLE.
//   - Net effect: busy high for exactly N cycles after the start cycle.
//   - New HI/LO are visible on out in the first cycle after busy falls.
//  Arithmetic:
//   - mult: signed 32x32 -> 64, {HI,LO}=product.
//   - multu: unsigned, same split.
//   - div: LO=signed quotient, HI=signed remainder.
//     Truncate toward zero; remainder takes sign of A.
//   - divu: unsigned quotient/remainder.
//   - div/divu with B==0: window still runs N cycles; HI/LO unchanged at commit.
//   - div 0x80000000 / -1: LO=0x80000000, HI=0.
//  mthi/mtlo in IDLE: HI (resp. LO) <= A at that edge, single cycle, no busy.
//  Any op while busy=1 is ignored; in-flight op unaffected.
//   The stall unit never issues one, but the block must tolerate it.
//  One op per cycle by construction; no simultaneous start/mt* case exists.
//  out never reflects uncommitted results.
//   A mf* in E during the window reads old HI/LO; the stall unit prevents this.
// STRUCTURE
//  defines.v: `MDU_NONE=0, `MDU_MULT=1, `MDU_MULTU=2, `MDU_DIV=3, `MDU_DIVU=4,
//   `MDU_MTHI=5, `MDU_MTLO=6.
//   CTRL derives isHILO (mult..mtlo, mfhi, mflo) from the same encodings.
//  Sub-module mdu_arith: combinational op,A,B -> hi_res,lo_res, B==0 flag.
//  mdu_hilo_ctrl holds only cnt/busy/HI/LO/pending state.
// TESTING
//  1 mult A=0xFFFFFFFD(-3) B=5 -> hilo_busy=1 in start cycle;
//    busy=1 for 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFF1.
//  2 multu A=0xFFFFFFFF B=2 -> after 5 cycles HI=1, LO=0xFFFFFFFE.
//  3 div A=-7 B=2 -> busy 10 cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
//    divu A=7 B=2 -> LO=3, HI=1.
//  4 mthi A=0x1234 then divu A=7 B=0 -> HI=0x1234 throughout and after 10 cycles.
//    LO also unchanged.
//  5 start mult A=2 B=3; issue mtlo A=0xDEAD at cycle 2 of window
//    -> ignored; final LO=6, HI=0.
//  6 start div; assert reset at cycle 4 -> next cycle busy=0, HI=LO=0.
//    A new mult issued right after completes normally.

Source files
------------

// File: rtl/mdu_hilo_ctrl_pkg.sv
// Shared op encodings, controller state constants and op-class helpers for the
// multiply/divide unit and its HI/LO controller.
package mdu_hilo_ctrl_pkg;

    typedef enum logic [2:0] {
        MDU_NONE  = 3'd0,
        MDU_MULT  = 3'd1,
        MDU_MULTU = 3'd2,
        MDU_DIV   = 3'd3,
        MDU_DIVU  = 3'd4,
        MDU_MTHI  = 3'd5,
        MDU_MTLO  = 3'd6
    } mdu_op_e;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // Ops that open a multi-cycle busy window.
    function automatic logic is_start(input logic [2:0] op);
        return (op == MDU_MULT) || (op == MDU_MULTU) || (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

    function automatic logic is_div(input logic [2:0] op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational multiply/divide datapath: produces the full HI/LO result for
// op/a/b and flags a zero divisor.
module mdu_arith
    import mdu_hilo_ctrl_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] hi_res,
    output logic [31:0] lo_res,
    output logic        b_zero
);

    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;
    logic        [31:0] divisor;
    logic               div_ovf;
    logic signed [31:0] quot_s;
    logic signed [31:0] rem_s;
    logic        [31:0] quot_u;
    logic        [31:0] rem_u;

    assign b_zero  = (b == 32'd0);
    // A zero divisor is replaced by 1 so the divider never sees x; the result is discarded anyway.
    assign divisor = b_zero ? 32'd1 : b;
    assign div_ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);

    assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign prod_u = {32'd0, a} * {32'd0, b};
    assign quot_s = div_ovf ? 32'sh8000_0000 : ($signed(a) / $signed(divisor));
    assign rem_s  = div_ovf ? 32'sd0 : ($signed(a) % $signed(divisor));
    assign quot_u = a / divisor;
    assign rem_u  = a % divisor;

    always_comb begin
        hi_res = 32'd0;
        lo_res = 32'd0;
        case (op)
            MDU_MULT:  {hi_res, lo_res} = prod_s;
            MDU_MULTU: {hi_res, lo_res} = prod_u;
            MDU_DIV: begin
                hi_res = rem_s;
                lo_res = quot_s;
            end
            MDU_DIVU: begin
                hi_res = rem_u;
                lo_res = quot_u;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mdu_hilo_ctrl.sv
// E-stage HI/LO controller: runs a fixed-length busy window per mult/div and
// commits the latched result to HI/LO when the window closes.
module mdu_hilo_ctrl
    import mdu_hilo_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        rd_sel,
    output logic [31:0] out,
    output logic        busy,
    output logic        hilo_busy
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
    localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [0:0]       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [31:0]      hi_q;
    logic [31:0]      lo_q;
    logic [31:0]      hi_nxt_q;
    logic [31:0]      lo_nxt_q;
    logic             commit_q;

    logic [31:0]      hi_res;
    logic [31:0]      lo_res;
    logic             b_zero;

    mdu_arith u_arith (
        .op     (op),
        .a      (A),
        .b      (B),
        .hi_res (hi_res),
        .lo_res (lo_res),
        .b_zero (b_zero)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            hi_nxt_q <= '0;
            lo_nxt_q <= '0;
            commit_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (is_start(op)) begin
                        hi_nxt_q <= hi_res;
                        lo_nxt_q <= lo_res;
                        // Divide by zero still burns the window but leaves HI/LO untouched.
                        commit_q <= !(is_div(op) && b_zero);
                        cnt_q    <= is_div(op) ? DIV_CNT : MULT_CNT;
                        state_q  <= ST_RUN;
                    end else if (op == MDU_MTHI) begin
                        hi_q <= A;
                    end else if (op == MDU_MTLO) begin
                        lo_q <= A;
                    end
                end
                ST_RUN: begin
                    // Ops arriving while running are dropped; the in-flight result is kept.
                    cnt_q <= cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        if (commit_q) begin
                            hi_q <= hi_nxt_q;
                            lo_q <= lo_nxt_q;
                        end
                        state_q <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    // busy is the registered controller state (RUN) made visible to the pipeline.
    assign busy      = (state_q == ST_RUN);
    assign hilo_busy = busy | (is_start(op) & ~busy);
    assign out       = rd_sel ? hi_q : lo_q;

endmodule

// File: tb/tb_mdu_hilo_ctrl.sv
// Self-checking bench for mdu_hilo_ctrl: directed scenarios plus random ops,
// checked every cycle against a behavioural HI/LO model.
module tb_mdu_hilo_ctrl;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    localparam logic [2:0] OP_NONE  = 3'd0;
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    // ---------------- clock / reset / DUT ----------------
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  op = OP_NONE;
    logic [31:0] a_in = '0;
    logic [31:0] b_in = '0;
    logic        rd_sel = 1'b0;
    logic [31:0] out;
    logic        busy;
    logic        hilo_busy;

    always #5 clk = ~clk;

    mdu_hilo_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk       (clk),
        .reset     (reset),
        .op        (op),
        .A         (a_in),
        .B         (b_in),
        .rd_sel    (rd_sel),
        .out       (out),
        .busy      (busy),
        .hilo_busy (hilo_busy)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_hi, m_lo, p_hi, p_lo;
    bit          p_ok;
    int          m_left;
    bit          model_ready = 1'b0;

    function automatic bit starts(input logic [2:0] o);
        return o == OP_MULT || o == OP_MULTU || o == OP_DIV || o == OP_DIVU;
    endfunction

    // Full-width 64-bit arithmetic; the 0x80000000 / -1 case falls out naturally.
    task automatic calc(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] h, output logic [31:0] l, output bit ok);
        longint      sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ok = 1'b1;
        h  = '0;
        l  = '0;
        case (o)
            OP_MULT:  begin p = sa * sb; h = p[63:32]; l = p[31:0]; end
            OP_MULTU: begin p = {32'd0, a} * {32'd0, b}; h = p[63:32]; l = p[31:0]; end
            OP_DIV: begin
                if (b == 0) ok = 1'b0;
                else begin q = sa / sb; r = sa % sb; p = q; l = p[31:0]; p = r; h = p[31:0]; end
            end
            OP_DIVU: begin
                if (b == 0) ok = 1'b0;
                else begin l = a / b; h = a % b; end
            end
            default: ;
        endcase
    endtask

    always @(posedge clk) begin
        logic [31:0] h, l;
        bit ok;
        if (reset) begin
            m_hi = '0; m_lo = '0; m_left = 0; p_ok = 1'b0;
            model_ready = 1'b1;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0 && p_ok) begin
                m_hi = p_hi;
                m_lo = p_lo;
            end
        end else if (starts(op)) begin
            calc(op, a_in, b_in, h, l, ok);
            p_hi = h; p_lo = l; p_ok = ok;
            m_left = (op == OP_DIV || op == OP_DIVU) ? DIV_N : MULT_N;
        end else if (op == OP_MTHI) begin
            m_hi = a_in;
        end else if (op == OP_MTLO) begin
            m_lo = a_in;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (model_ready) begin
            chk("busy", {31'd0, busy}, {31'd0, m_left > 0});
            chk("hilo_busy", {31'd0, hilo_busy}, {31'd0, (m_left > 0) || starts(op)});
            chk("out", out, rd_sel ? m_hi : m_lo);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        op = o; a_in = a; b_in = b;
        @(posedge clk); #1;
        op = OP_NONE;
    endtask

    // Counts busy cycles until busy drops; returns at the negedge where it is low.
    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(negedge clk);
            if (busy) n++;
        end while (busy && n < 200);
        if (n >= 200) chk("busy_timeout", 32'd1, 32'd0);
    endtask

    task automatic chk_hilo(input string name, input logic [31:0] eh, input logic [31:0] el);
        logic saved;
        saved = rd_sel;
        #2 rd_sel = 1'b1;
        #1 chk({name, "_hi"}, out, eh);
        rd_sel = 1'b0;
        #1 chk({name, "_lo"}, out, el);
        rd_sel = saved;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        logic [31:0] pick_b [6];
        pick_b = '{32'd0, 32'hFFFF_FFFF, 32'd1, 32'h8000_0000, 32'd7, 32'd3};

        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk_hilo("reset", 32'd0, 32'd0);

        // mult -3 * 5
        @(posedge clk); #1;
        op = OP_MULT; a_in = 32'hFFFF_FFFD; b_in = 32'd5;
        @(negedge clk);
        chk("start_hilo_busy", {31'd0, hilo_busy}, 32'd1);
        @(posedge clk); #1; op = OP_NONE;
        wait_done(n);
        chk("mult_cycles", n, MULT_N);
        chk_hilo("mult", 32'hFFFF_FFFF, 32'hFFFF_FFF1);

        @(posedge clk); #1;
        issue(OP_MULTU, 32'hFFFF_FFFF, 32'd2);
        wait_done(n);
        chk_hilo("multu", 32'd1, 32'hFFFF_FFFE);

        @(posedge clk); #1;
        issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        wait_done(n);
        chk("div_cycles", n, DIV_N);
        chk_hilo("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

        @(posedge clk); #1;
        issue(OP_DIVU, 32'd7, 32'd2);
        wait_done(n);
        chk_hilo("divu", 32'd1, 32'd3);

        @(posedge clk); #1;
        issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(n);
        chk_hilo("div_ovf", 32'd0, 32'h8000_0000);

        // mthi/mtlo then divide by zero: HI/LO must survive the whole window
        @(posedge clk); #1;
        issue(OP_MTHI, 32'h1234, 32'd0);
        issue(OP_MTLO, 32'h5678, 32'd0);
        issue(OP_DIVU, 32'd7, 32'd0);
        @(negedge clk);
        chk_hilo("divz_mid", 32'h1234, 32'h5678);
        wait_done(n);
        chk("divz_cycles", n, DIV_N - 1);
        chk_hilo("divz", 32'h1234, 32'h5678);

        // mtlo inside a mult window is ignored
        @(posedge clk); #1;
        issue(OP_MULT, 32'd2, 32'd3);
        issue(OP_MTLO, 32'hDEAD, 32'd0);
        wait_done(n);
        chk_hilo("mt_ignored", 32'd0, 32'd6);

        // reset mid-divide aborts it
        @(posedge clk); #1;
        issue(OP_DIV, 32'd100, 32'd7);
        repeat (2) begin @(posedge clk); #1; end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk_hilo("abort", 32'd0, 32'd0);
        @(posedge clk); #1;
        issue(OP_MULT, 32'd4, 32'd5);
        wait_done(n);
        chk_hilo("after_abort", 32'd0, 32'd20);

        // random phase, checked by the model every cycle
        @(posedge clk); #1;
        for (int i = 0; i < 400; i++) begin
            reset  = ($urandom_range(0, 99) == 0);
            op     = ($urandom_range(0, 2) == 0) ? OP_NONE : 3'($urandom_range(1, 6));
            a_in   = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom;
            b_in   = ($urandom_range(0, 2) == 0) ? pick_b[$urandom_range(0, 5)] : $urandom;
            rd_sel = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        reset = 1'b0;
        op = OP_NONE;
        wait_done(n);
        chk_hilo("final", m_hi, m_lo);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
